key_seq_reader: RTL and testbench

- Bus-side initiator for the serial key device on the BA12 window.
- On `start`, requests the bus and issues NSTEPS read cycles, each with a 4-bit challenge nibble on BA7..BA4.
- Samples the key's serial data bit (`sdrd`) on each read and collects the bits into a response word.
- Compares the response word against an expected signature and reports `pass` or fail to the host controller.

---
 rtl/keyrd_pkg.sv | 13 +
 rtl/keyrd_lfsr4.sv | 19 +
 rtl/key_seq_reader.sv | 112 +++++++++++
 tb/tb_key_seq_reader.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/keyrd_pkg.sv
// keyrd_pkg: shared state encoding, bus idle levels, LFSR tap set and timeout limit for the key sequence reader
package keyrd_pkg;
    typedef enum logic [2:0] {IDLE, REQ, ADDR, SAMPLE, GAP, CHECK} state_t;
    localparam logic SSER_IDLE = 1'b1;
    localparam logic BA13_IDLE = 1'b1;
    localparam logic BA12_IDLE = 1'b0;
    localparam logic BRW_IDLE = 1'b1;
    localparam logic [3:0] LFSR_TAPS = 4'b1100;
    localparam logic [7:0] TIMEOUT_LIM = 8'd255;
    function automatic logic [3:0] lfsr_next(input logic [3:0] q);
        return {q[2:0], ^(q & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/keyrd_lfsr4.sv
// keyrd_lfsr4: 4-bit Fibonacci LFSR producing challenge nibbles
// Ports: clk, rst_n (async, active low); load reloads SEED; step advances one position; q is the current nibble
module keyrd_lfsr4
    import keyrd_pkg::*;
#(
    parameter logic [3:0] SEED = 4'h1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    output logic [3:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= SEED;
        else if (load) q <= SEED;
        else if (step) q <= lfsr_next(q);
    end
endmodule

// File: rtl/key_seq_reader.sv
// key_seq_reader: bus initiator running a challenge/response read sequence against the serial key device
// Ports: clk, rst_n (async, active low); host side start, resp_expect, busy, done, pass, resp;
//        bus side bus_req/bus_gnt, sser_n, ba13, ba12, ba_nib, br_w, sdrd.
// Optional: define KEYRD_TIMEOUT_EN to abort a grant wait after 255 clocks and add a timeout pulse output.
module key_seq_reader
    import keyrd_pkg::*;
#(
    parameter int         NSTEPS     = 8,
    parameter logic [3:0] LFSR_SEED  = 4'h1,
    parameter int         GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NSTEPS-1:0] resp_expect,
    input  logic              bus_gnt,
    input  logic              sdrd,
    output logic              bus_req,
    output logic              sser_n,
    output logic              ba13,
    output logic              ba12,
    output logic [3:0]        ba_nib,
    output logic              br_w,
    output logic              busy,
    output logic              done,
    output logic              pass,
`ifdef KEYRD_TIMEOUT_EN
    output logic              timeout,
`endif
    output logic [NSTEPS-1:0] resp
);
    state_t state, next;
    logic [4:0] step;
    logic [7:0] gcnt;
    logic [3:0] lfsr_q, nib_d;
    logic [NSTEPS-1:0] resp_nx;
    logic accept, last, bus_on, to_hit;

    keyrd_lfsr4 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk(clk), .rst_n(rst_n), .load(accept), .step(state == SAMPLE), .q(lfsr_q)
    );

    assign accept = state == IDLE && start;
    assign last = step == 5'(NSTEPS - 1);
    // the captured word with the bit being read this cycle merged in, so CHECK can be entered with a complete result
    assign resp_nx = resp | (NSTEPS'(sdrd) << step);
    // when going straight from SAMPLE back to ADDR the LFSR steps on the same edge, so present its next value
    assign nib_d = state == SAMPLE ? lfsr_next(lfsr_q) : lfsr_q;
    assign bus_on = next == ADDR || next == SAMPLE;

`ifdef KEYRD_TIMEOUT_EN
    logic [7:0] tcnt;
    assign to_hit = state == REQ && !bus_gnt && tcnt == TIMEOUT_LIM - 8'd1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= 8'd0;
            timeout <= 1'b0;
        end else begin
            tcnt <= state == REQ ? tcnt + 8'd1 : 8'd0;
            timeout <= to_hit;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    next = start ? REQ : IDLE;
            REQ:     next = bus_gnt ? ADDR : (to_hit ? CHECK : REQ);
            ADDR:    next = SAMPLE;
            SAMPLE:  next = last ? CHECK : (GAP_CYCLES == 0 ? ADDR : GAP);
            GAP:     next = gcnt == 8'(GAP_CYCLES - 1) ? ADDR : GAP;
            CHECK:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    // every output is registered from the next state so the bus pins never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step <= 5'd0;
            gcnt <= 8'd0;
            bus_req <= 1'b0;
            sser_n <= SSER_IDLE;
            ba13 <= BA13_IDLE;
            ba12 <= BA12_IDLE;
            ba_nib <= 4'h0;
            br_w <= BRW_IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            resp <= '0;
        end else begin
            state <= next;
            gcnt <= state == GAP ? gcnt + 8'd1 : 8'd0;
            step <= accept ? 5'd0 : (state == SAMPLE ? step + 5'd1 : step);
            bus_req <= next != IDLE;
            busy <= next != IDLE;
            sser_n <= bus_on ? 1'b0 : SSER_IDLE;
            ba13 <= bus_on ? 1'b0 : BA13_IDLE;
            ba12 <= bus_on ? 1'b1 : BA12_IDLE;
            br_w <= bus_on ? 1'b1 : BRW_IDLE;
            ba_nib <= bus_on ? nib_d : 4'h0;
            done <= next == CHECK;
            resp <= accept ? '0 : (state == SAMPLE ? resp_nx : resp);
            pass <= accept ? 1'b0 : (next == CHECK ? !to_hit && resp_nx == resp_expect : pass);
        end
    end
endmodule

// File: tb/tb_key_seq_reader.sv
// tb_key_seq_reader: scoreboard bench for key_seq_reader with a keyed serial device model
module tb_key_seq_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [7:0] resp_expect = 8'h00;
    logic bus_gnt = 1'b0;
    logic sdrd;
    logic bus_req, sser_n, ba13, ba12, br_w, busy, done, pass, timeout_w;
    logic [3:0] ba_nib;
    logic [7:0] resp;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_nib[$];
    logic [9:0] exp_res[$];
    logic [3:0] nibs [8] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA};
    // device answers 1 for challenges 1, 4, 9 and D: reading 1,2,4,9,3,6,D,A yields 1,0,1,1,0,0,1,0 = 8'h4D
    logic [15:0] key_map = 16'h2212;
    logic [3:0] cur_nib = 4'h0;
    int run = 0;

    assign sdrd = !sser_n & key_map[ba_nib];

    always #5 clk = ~clk;

    key_seq_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .resp_expect(resp_expect),
        .bus_gnt(bus_gnt), .sdrd(sdrd), .bus_req(bus_req), .sser_n(sser_n),
        .ba13(ba13), .ba12(ba12), .ba_nib(ba_nib), .br_w(br_w), .busy(busy),
        .done(done), .pass(pass),
`ifdef KEYRD_TIMEOUT_EN
        .timeout(timeout_w),
`endif
        .resp(resp)
    );
`ifndef KEYRD_TIMEOUT_EN
    assign timeout_w = 1'b0;
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: pops expected challenges on each bus access and expected results on each done pulse
    always @(negedge clk) begin
        if (!rst_n) run = 0;
        else begin
            if (!sser_n) begin
                if (run == 0) begin
                    if (exp_nib.size() == 0) check("unexpected_access", 32'(ba_nib), 32'hFFFF);
                    else cur_nib = exp_nib.pop_front();
                end
                check("access", {25'd0, ba13, ba12, br_w, ba_nib}, {25'd0, 3'b011, cur_nib});
                run++;
            end else if (run != 0) begin
                check("access_len", 32'(run), 32'd2);
                run = 0;
            end
            if (done) begin
                check("busy_at_done", 32'(busy), 32'd1);
                if (exp_res.size() == 0) check("unexpected_done", 32'(resp), 32'hFFFF);
                else check("result", {22'd0, timeout_w, pass, resp}, {22'd0, exp_res.pop_front()});
            end
        end
    end

    task automatic run_seq(input logic [7:0] expv, input int gdelay);
        logic ok;
        int cnt;
        logic exp_pass;
        exp_pass = expv == 8'h4D;
        @(negedge clk);
        resp_expect = expv;
        start = 1'b1;
        for (int i = 0; i < 8; i++) exp_nib.push_back(nibs[i]);
        exp_res.push_back({1'b0, exp_pass, 8'h4D});
        @(negedge clk);
        start = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < gdelay; i++) begin
            ok &= bus_req & sser_n & busy;
            @(negedge clk);
        end
        if (gdelay > 0) check("req_wait", 32'(ok), 32'd1);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        check("first_access", {27'd0, sser_n, ba_nib}, {27'd0, 1'b0, 4'h1});
        cnt = 1;
        while (!done && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("latency", 32'(cnt), 32'd31);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ignored", {29'd0, busy, bus_req, done}, 32'd0);
        check("result_hold", {23'd0, pass, resp}, {23'd0, exp_pass, 8'h4D});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        @(negedge clk);
        check("reset_values", {12'd0, bus_req, sser_n, ba13, ba12, ba_nib, br_w, busy, done, pass, resp},
              {12'd0, 20'b0_1_1_0_0000_1_0_0_0_00000000});
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_values", {12'd0, bus_req, sser_n, ba13, ba12, ba_nib, br_w, busy, done, pass, resp},
              {12'd0, 20'b0_1_1_0_0000_1_0_0_0_00000000});

        run_seq(8'h4D, 0);
        run_seq(8'h4C, 0);
        run_seq(8'h4D, 10);

        @(negedge clk);
        resp_expect = 8'h4D;
        start = 1'b1;
        for (int i = 0; i < 8; i++) exp_nib.push_back(nibs[i]);
        exp_res.push_back({1'b0, 1'b1, 8'h4D});
        @(negedge clk);
        start = 1'b0;
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        repeat (8) @(negedge clk);
        check("step3_access", {27'd0, sser_n, ba_nib}, {27'd0, 1'b0, 4'h4});
        #2 rst_n = 1'b0;
        #1 check("reset_mid", {21'd0, sser_n, ba13, ba12, ba_nib, br_w, bus_req, busy, done},
                 {21'd0, 11'b1_1_0_0000_1_0_0_0});
        exp_nib.delete();
        exp_res.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check("no_done_after_reset", 32'(cnt), 32'd0);
        run_seq(8'h4D, 0);

`ifdef KEYRD_TIMEOUT_EN
        @(negedge clk);
        start = 1'b1;
        exp_res.push_back({1'b1, 1'b0, 8'h00});
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!done && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_latency", 32'(cnt), 32'd255);
        @(negedge clk);
        check("timeout_release", {30'd0, bus_req, busy}, 32'd0);
`endif

        repeat (5) @(negedge clk);
        check("queues_drained", 32'(exp_nib.size() + exp_res.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
